// File: rtl/arf_rw_ctrl_pkg.sv
// Shared constants, types and helpers for the register-file request control stage.
package arf_rw_ctrl_pkg;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned DW    = 85;

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    INIT     = 2'd1,
    RUN      = 2'd2
  } state_t;

  // Array word: parity in bit DW, payload below it.
  typedef logic [DW:0] arr_word_t;

  // Even-parity bit for a payload.
  function automatic logic par_f(input logic [DW-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/arf_rw_ctrl_rd_pipe.sv
// Three-stage read pipeline: array read request, data/bypass capture, response with parity check.
module arf_rw_ctrl_rd_pipe
  import arf_rw_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_rd_acc,
  input  logic [AW-1:0] i_rd_adr,
  input  logic          i_arr_wen,
  input  logic [AW-1:0] i_arr_wadr,
  input  logic [DW-1:0] i_arr_wpld,
  input  arr_word_t     i_arr_rdat,
  output logic          o_arr_ren,
  output logic [AW-1:0] o_arr_radr,
  output logic          o_rsp_vld,
  output logic [DW-1:0] o_rsp_dat,
  output logic          o_rsp_perr
);

  logic          r_ren;
  logic [AW-1:0] r_radr;
  logic          r_s2_vld;
  logic          r_s2_byp;
  logic [DW-1:0] r_byp;
  logic          r_rsp_vld;
  logic [DW-1:0] r_rsp_dat;
  logic          r_rsp_perr;
  logic          w_coll;

  // Array is read-before-write: a same-address write this cycle must reach the reader via bypass.
  assign w_coll = r_ren & i_arr_wen & (i_arr_wadr == r_radr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ren      <= 1'b0;
      r_radr     <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_byp   <= 1'b0;
      r_byp      <= '0;
      r_rsp_vld  <= 1'b0;
      r_rsp_dat  <= '0;
      r_rsp_perr <= 1'b0;
    end else begin
      r_ren    <= i_rd_acc;
      if (i_rd_acc) r_radr <= i_rd_adr;
      r_s2_vld <= r_ren;
      r_s2_byp <= w_coll;
      if (w_coll) r_byp <= i_arr_wpld;
      r_rsp_vld <= r_s2_vld;
      // Payload holds between responses; perr only meaningful alongside rsp_vld.
      if (r_s2_vld) begin
        r_rsp_dat  <= r_s2_byp ? r_byp : i_arr_rdat[DW-1:0];
        r_rsp_perr <= ~r_s2_byp & (par_f(i_arr_rdat[DW-1:0]) ^ i_arr_rdat[DW]);
      end else begin
        r_rsp_perr <= 1'b0;
      end
    end
  end

  assign o_arr_ren  = r_ren;
  assign o_arr_radr = r_radr;
  assign o_rsp_vld  = r_rsp_vld;
  assign o_rsp_dat  = r_rsp_dat;
  assign o_rsp_perr = r_rsp_perr;

endmodule

// File: rtl/arf_rw_ctrl.sv
// Request-side control for the 128x86 1R1W register-file array: FSM, write path, read pipe.
// Optional post-reset zero-fill of the array is enabled by ARF_RW_CTRL_INIT_EN.
module arf_rw_ctrl
  import arf_rw_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_vld,
  output logic          wr_rdy,
  input  logic [AW-1:0] wr_adr,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_vld,
  output logic          rd_rdy,
  input  logic [AW-1:0] rd_adr,
  output logic          rd_rsp_vld,
  output logic [DW-1:0] rd_rsp_dat,
  output logic          rd_rsp_perr,
  output logic          arr_wen,
  output logic [AW-1:0] arr_wadr,
  output arr_word_t     arr_wdat,
  output logic          arr_ren,
  output logic [AW-1:0] arr_radr,
  input  arr_word_t     arr_rdat,
  output logic          init_done
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_run;
  logic          r_wen;
  logic [AW-1:0] r_wadr;
  arr_word_t     r_wdat;
  logic          w_wen_nxt;
  logic [AW-1:0] w_wadr_nxt;
  arr_word_t     w_wdat_nxt;
  logic          w_wr_acc;
  logic          w_rd_acc;

`ifdef ARF_RW_CTRL_INIT_EN
  logic [AW-1:0] r_init_cnt;

  // Zero-fill sweep address; restarts from 0 on every reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_cnt <= '0;
    end else if (r_state == INIT) begin
      r_init_cnt <= r_init_cnt + AW'(1);
    end
  end
`endif

  assign w_wr_acc = wr_vld & r_run;
  assign w_rd_acc = rd_vld & r_run;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RST_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next array write-port values.
  always_comb begin
    w_state_nxt = r_state;
    w_wen_nxt   = w_wr_acc;
    w_wadr_nxt  = w_wr_acc ? wr_adr : r_wadr;
    w_wdat_nxt  = w_wr_acc ? {par_f(wr_dat), wr_dat} : r_wdat;
    case (r_state)
      RST_WAIT: begin
`ifdef ARF_RW_CTRL_INIT_EN
        w_state_nxt = INIT;
`else
        w_state_nxt = RUN;
`endif
      end
      INIT: begin
`ifdef ARF_RW_CTRL_INIT_EN
        w_wen_nxt  = 1'b1;
        w_wadr_nxt = r_init_cnt;
        w_wdat_nxt = '0;
        if (r_init_cnt == AW'(DEPTH - 1)) w_state_nxt = RUN;
`else
        w_state_nxt = RST_WAIT;
`endif
      end
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = RST_WAIT;
    endcase
  end

  // Registered write port and ready; clearing r_wen on reset squashes any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run  <= 1'b0;
      r_wen  <= 1'b0;
      r_wadr <= '0;
      r_wdat <= '0;
    end else begin
      r_run  <= (w_state_nxt == RUN);
      r_wen  <= w_wen_nxt;
      r_wadr <= w_wadr_nxt;
      r_wdat <= w_wdat_nxt;
    end
  end

  arf_rw_ctrl_rd_pipe u_rd_pipe (
    .clk        (clk),
    .rst        (rst),
    .i_rd_acc   (w_rd_acc),
    .i_rd_adr   (rd_adr),
    .i_arr_wen  (r_wen),
    .i_arr_wadr (r_wadr),
    .i_arr_wpld (r_wdat[DW-1:0]),
    .i_arr_rdat (arr_rdat),
    .o_arr_ren  (arr_ren),
    .o_arr_radr (arr_radr),
    .o_rsp_vld  (rd_rsp_vld),
    .o_rsp_dat  (rd_rsp_dat),
    .o_rsp_perr (rd_rsp_perr)
  );

  assign wr_rdy    = r_run;
  assign rd_rdy    = r_run;
  assign init_done = r_run;
  assign arr_wen   = r_wen;
  assign arr_wadr  = r_wadr;
  assign arr_wdat  = r_wdat;

endmodule

// File: tb/tb_arf_rw_ctrl.sv
// Randomized bench for arf_rw_ctrl with a behavioural array and a memory/queue reference model.
module tb_arf_rw_ctrl;

  localparam int AW    = 7;
  localparam int DW    = 85;
  localparam int DEPTH = 128;
`ifdef ARF_RW_CTRL_INIT_EN
  localparam int INIT_CYC = 129;
  localparam bit INIT_ON  = 1'b1;
`else
  localparam int INIT_CYC = 1;
  localparam bit INIT_ON  = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          wr_vld, wr_rdy, rd_vld, rd_rdy;
  logic [AW-1:0] wr_adr, rd_adr, arr_wadr, arr_radr;
  logic [DW-1:0] wr_dat, rd_rsp_dat;
  logic          rd_rsp_vld, rd_rsp_perr, arr_wen, arr_ren, init_done;
  logic [DW:0]   arr_wdat, arr_rdat;

  arf_rw_ctrl dut (
    .clk(clk), .rst(rst),
    .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_adr(wr_adr), .wr_dat(wr_dat),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_adr(rd_adr),
    .rd_rsp_vld(rd_rsp_vld), .rd_rsp_dat(rd_rsp_dat), .rd_rsp_perr(rd_rsp_perr),
    .arr_wen(arr_wen), .arr_wadr(arr_wadr), .arr_wdat(arr_wdat),
    .arr_ren(arr_ren), .arr_radr(arr_radr), .arr_rdat(arr_rdat),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural read-before-write array, with optional bit-3 corruption on reads of address 5.
  logic [DW:0] mem [DEPTH];
  bit          flip5;
  always @(posedge clk) begin
    if (arr_ren) arr_rdat <= mem[arr_radr] ^ ((flip5 && arr_radr == 7'd5) ? 86'h8 : 86'h0);
    if (arr_wen) mem[arr_wadr] <= arr_wdat;
  end

  // Reference model state.
  typedef struct {
    int          due;
    logic [DW-1:0] dat;
    logic        perr;
  } rsp_t;
  logic [DW-1:0] gold [DEPTH];
  rsp_t          q[$];
  int            cyc, low_cnt;
  bit            m_wen, m_ren;
  logic [AW-1:0] m_wadr, m_radr;
  logic [DW:0]   m_wdat;
  logic [DW-1:0] m_last;
  int            n_cmp, n_err;

  task automatic chk(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_dat();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // Advance one clock and compare every observable output against the model.
  task automatic tick();
    @(posedge clk);
    cyc++;
    low_cnt = rst ? 0 : low_cnt + 1;
    #1;
    chk("wr_rdy", wr_rdy, low_cnt >= INIT_CYC);
    chk("rd_rdy", rd_rdy, low_cnt >= INIT_CYC);
    chk("init_done", init_done, low_cnt >= INIT_CYC);
    chk("arr_wen", arr_wen, m_wen);
    if (m_wen) begin
      chk("arr_wadr", arr_wadr, m_wadr);
      chk("arr_wdat", arr_wdat, m_wdat);
    end
    chk("arr_ren", arr_ren, m_ren);
    if (m_ren) chk("arr_radr", arr_radr, m_radr);
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rsp_vld", rd_rsp_vld, 1'b1);
      chk("rsp_dat", rd_rsp_dat, q[0].dat);
      chk("rsp_perr", rd_rsp_perr, q[0].perr);
      m_last = q[0].dat;
      void'(q.pop_front());
    end else begin
      chk("rsp_vld_idle", rd_rsp_vld, 1'b0);
      chk("rsp_dat_hold", rd_rsp_dat, m_last);
    end
  endtask

  // Drive one cycle of inputs, update the model with what the DUT should accept, then clock.
  task automatic drive(input bit r, input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit rv, input logic [AW-1:0] ra);
    bit            run, wacc, racc;
    logic [DW-1:0] d;
    rst = r; wr_vld = wv; wr_adr = wa; wr_dat = wd; rd_vld = rv; rd_adr = ra;
    run  = (low_cnt >= INIT_CYC);
    wacc = wv && run && !r;
    racc = rv && run && !r;
    if (r) begin
      q.delete();
      m_wen  = 1'b0;
      m_ren  = 1'b0;
      m_last = '0;
    end else begin
      m_wen = wacc;
      if (wacc) begin
        m_wadr   = wa;
        m_wdat   = {^wd, wd};
        gold[wa] = wd;
      end
      if (INIT_ON && low_cnt >= 1 && low_cnt <= 128) begin
        m_wen  = 1'b1;
        m_wadr = AW'(low_cnt - 1);
        m_wdat = '0;
        gold[AW'(low_cnt - 1)] = '0;
      end
      m_ren = racc;
      if (racc) begin
        m_radr = ra;
        d = gold[ra];
        if (flip5 && ra == 7'd5 && !(wacc && wa == 7'd5)) begin
          d[3] = ~d[3];
          q.push_back('{due: cyc + 3, dat: d, perr: 1'b1});
        end else begin
          q.push_back('{due: cyc + 3, dat: d, perr: 1'b0});
        end
      end
    end
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    logic [DW-1:0] d;
    int            b;
    n_cmp = 0; n_err = 0; cyc = 0; low_cnt = 0;
    flip5 = 1'b0; m_last = '0; arr_rdat = '0;
    m_wen = 1'b0; m_ren = 1'b0; m_wadr = '0; m_radr = '0; m_wdat = '0;
    rst = 1'b1; wr_vld = 1'b0; rd_vld = 1'b0; wr_adr = '0; rd_adr = '0; wr_dat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      d = rnd_dat();
      mem[i] = {^d, d};
      gold[i] = d;
    end

    // Reset pulse with requests asserted: nothing may be accepted.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 7'h11, rnd_dat(), 1'b1, 7'h11);
    chk("reset_rsp_dat", rd_rsp_dat, '0);
    chk("reset_arr_wdat", arr_wdat, '0);

    // Release and wait for RUN within a bounded number of cycles.
    b = 0;
    while (low_cnt < INIT_CYC && b < 300) begin
      idle(1);
      b++;
    end
    chk("init_done_reached", init_done, 1'b1);
    chk("init_cycles", b, INIT_CYC);

    // Read 0x45 (zero after a zero-fill, else preloaded contents).
    drive(1'b0, 1'b0, '0, '0, 1'b1, 7'h45);
    idle(4);

    // Write then read the same address two cycles later.
    drive(1'b0, 1'b1, 7'h45, 85'h1_2345_6789_ABCD_EF01_2345, 1'b0, '0);
    idle(1);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 7'h45);
    idle(4);

    // Same-cycle write and read to 0x7F: response must carry the new data.
    drive(1'b0, 1'b1, 7'h7F, rnd_dat(), 1'b1, 7'h7F);
    idle(4);

    // Back-to-back reads of 0..7 with address 5 corrupted in the array.
    flip5 = 1'b1;
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, '0, '0, 1'b1, AW'(i));
    idle(4);
    flip5 = 1'b0;

    // Random traffic over a narrow address window to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 149) == 0), $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)),
            rnd_dat(), $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)));
    end
    b = 0;
    while (low_cnt < INIT_CYC && b < 300) begin
      idle(1);
      b++;
    end
    idle(4);

    // Read+write accepted, then reset one cycle later: no response, write squashed.
    drive(1'b0, 1'b1, 7'h22, rnd_dat(), 1'b1, 7'h22);
    drive(1'b1, 1'b1, 7'h23, rnd_dat(), 1'b1, 7'h23);
    chk("squash_wen", arr_wen, 1'b0);
    chk("squash_ren", arr_ren, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
    idle(1);
    chk("rdy_after_release", rd_rdy, (INIT_CYC == 1) ? 1'b1 : 1'b0);
    b = 0;
    while (low_cnt < INIT_CYC && b < 300) begin
      idle(1);
      b++;
    end
    drive(1'b0, 1'b1, 7'h30, rnd_dat(), 1'b1, 7'h30);
    idle(5);
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
